// File: rtl/narrow_32_to_16_tx_pkg.sv
// Shared definitions for the 32<->16 sign-extension narrowing path.
// Both the transmit and receive ends import this package, so they agree on
// the widths, the FSM encoding and the compact test.
package narrow_32_to_16_tx_pkg;

  localparam int NARROW_W = 16;
  localparam int WIDE_W   = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND_ONE = 2'd1,
    SEND_LO  = 2'd2,
    SEND_HI  = 2'd3
  } tx_state_e;

  // A word is compact when bits [31:15] are all equal. The receiver can then
  // rebuild it by sign-extending the low 16 bits.
  function automatic logic fits_narrow(input logic [WIDE_W-1:0] w);
    return (w[WIDE_W-1:NARROW_W-1] == '0) || (w[WIDE_W-1:NARROW_W-1] == '1);
  endfunction

endpackage

// File: rtl/narrow_32_to_16_tx_fits.sv
// Combinational compact test. It reports whether a signed 32-bit word lies
// in -32768..32767.
module fits_in_16
  import narrow_32_to_16_tx_pkg::*;
(
  input  logic [WIDE_W-1:0] in,
  output logic              fits
);

  assign fits = fits_narrow(in);

endmodule

// File: rtl/narrow_32_to_16_tx.sv
// Transmit end of the 16-to-32 sign-extension path. A word that fits in 16
// signed bits leaves as a single compact beat. Any other word leaves as a
// low beat followed by a high beat. All beat outputs are registered.
module narrow_32_to_16_tx
  import narrow_32_to_16_tx_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDE_W-1:0]   in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NARROW_W-1:0] out_data,
  output logic                out_compact,
  output logic                out_last,
  output logic [CNT_W-1:0]    expanded_cnt
);

  tx_state_e           state_q;
  logic [WIDE_W-1:0]   hold_q;
  logic                out_valid_q;
  logic [NARROW_W-1:0] out_data_q;
  logic                out_compact_q;
  logic                out_last_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic                in_fits;
  logic                out_xfer;
  logic                unused_hold_lo;

  fits_in_16 u_fits (
    .in   (in_data),
    .fits (in_fits)
  );

  // Only IDLE accepts a new word. Each word is fully drained before the next
  // one is taken.
  assign in_ready = (state_q == IDLE);
  assign out_xfer = out_valid_q & out_ready;

  // The low beat is loaded straight from in_data at capture time. The holding
  // register still keeps the full word, so it matches what the receiver
  // rebuilds.
  assign unused_hold_lo = ^hold_q[NARROW_W-1:0];

  // Saturating next value for the expanded-word counter.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
  end

  // Beat sequencer: capture in IDLE, then hold each beat until it is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      hold_q        <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_compact_q <= 1'b0;
      out_last_q    <= 1'b0;
      cnt_q         <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            hold_q      <= in_data;
            out_valid_q <= 1'b1;
            out_data_q  <= in_data[NARROW_W-1:0];
            if (in_fits) begin
              state_q       <= SEND_ONE;
              out_compact_q <= 1'b1;
              out_last_q    <= 1'b1;
            end else begin
              state_q       <= SEND_LO;
              out_compact_q <= 1'b0;
              out_last_q    <= 1'b0;
              cnt_q         <= cnt_d;
            end
          end
        end
        SEND_ONE: begin
          if (out_xfer) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        SEND_LO: begin
          if (out_xfer) begin
            state_q    <= SEND_HI;
            out_data_q <= hold_q[WIDE_W-1:NARROW_W];
            out_last_q <= 1'b1;
          end
        end
        SEND_HI: begin
          if (out_xfer) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_compact  = out_compact_q;
  assign out_last     = out_last_q;
  assign expanded_cnt = cnt_q;

endmodule

// File: tb/tb_narrow_32_to_16_tx.sv
// Scoreboard bench for narrow_32_to_16_tx. Stimulus pushes the hand-computed
// beats for each word into a queue. A monitor pops and compares every
// accepted beat.
module tb_narrow_32_to_16_tx;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_data;
  logic             out_compact;
  logic             out_last;
  logic [CNT_W-1:0] expanded_cnt;

  always #5 clk = ~clk;

  narrow_32_to_16_tx #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_compact  (out_compact),
    .out_last     (out_last),
    .expanded_cnt (expanded_cnt)
  );

  typedef struct packed {
    logic [15:0] data;
    logic        compact;
    logic        last;
  } beat_t;

  typedef struct {
    logic [31:0] w;
    int          nb;
    logic [15:0] b0;
    logic [15:0] b1;
    int          cnt;
  } vec_t;

  beat_t sb[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  // Directed words, their expected beats, and the counter afterwards (CNT_W=2).
  vec_t v_main[7] = '{
    '{32'h00007FFF, 1, 16'h7FFF, 16'h0000, 0},
    '{32'hFFFF8000, 1, 16'h8000, 16'h0000, 0},
    '{32'h00008000, 2, 16'h8000, 16'h0000, 1},
    '{32'hFFFF7FFF, 2, 16'h7FFF, 16'hFFFF, 2},
    '{32'h00000000, 1, 16'h0000, 16'h0000, 2},
    '{32'hFFFFFFFF, 1, 16'hFFFF, 16'h0000, 2},
    '{32'h80000000, 2, 16'h0000, 16'h8000, 3}
  };

  // Expanded words issued after a reset, to drive the counter into saturation.
  vec_t v_sat[5] = '{
    '{32'h00010000, 2, 16'h0000, 16'h0001, 1},
    '{32'hFFFE0000, 2, 16'h0000, 16'hFFFE, 2},
    '{32'h7FFFFFFF, 2, 16'hFFFF, 16'h7FFF, 3},
    '{32'h80000001, 2, 16'h0001, 16'h8000, 3},
    '{32'h00123456, 2, 16'h3456, 16'h0012, 3}
  };

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare accepted beats and check stability while stalled.
  initial begin
    beat_t prev;
    beat_t cur;
    beat_t exp;
    bit    stalled;
    stalled = 1'b0;
    prev    = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 1'b0;
        continue;
      end
      cur = {out_data, out_compact, out_last};
      if (stalled) begin
        chk("stall_valid_held", {31'd0, out_valid}, 32'd1);
        chk("stall_beat_stable", {14'd0, cur}, {14'd0, prev});
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got 0x%0h expected no beat at %0t", out_data, $time);
        end else begin
          exp = sb.pop_front();
          chk("beat", {14'd0, cur}, {14'd0, exp});
        end
      end
      stalled = out_valid && !out_ready;
      prev    = cur;
    end
  end

  // Issue one word and push its expected beats. Then check first-beat latency.
  task automatic send(input vec_t v);
    beat_t b;
    int    k;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = v.w;
    b.data = v.b0; b.compact = (v.nb == 1); b.last = (v.nb == 1);
    sb.push_back(b);
    if (v.nb == 2) begin
      b.data = v.b1; b.compact = 1'b0; b.last = 1'b1;
      sb.push_back(b);
    end
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (k == 50) chk("in_ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("first_beat_latency", {31'd0, out_valid}, 32'd1);
    chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 60; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) break;
    end
    if (k == 60) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t bp;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_data", {16'd0, out_data}, 32'd0);
    chk("rst_compact_last", {30'd0, out_compact, out_last}, 32'd0);
    chk("rst_cnt", {30'd0, expanded_cnt}, 32'd0);

    // out_ready in IDLE has no effect.
    @(posedge clk); #1 out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_no_valid", {31'd0, out_valid}, 32'd0);
    end

    foreach (v_main[i]) begin
      send(v_main[i]);
      drain();
      chk("expanded_cnt", {30'd0, expanded_cnt}, v_main[i].cnt);
    end

    // Backpressure during SEND_LO, with junk on the input that must be ignored.
    bp = '{32'h12345678, 2, 16'h5678, 16'h1234, 3};
    out_ready = 1'b0;
    send(bp);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = 32'h0000_0001;
    repeat (5) begin
      @(negedge clk);
      chk("bp_data", {16'd0, out_data}, 32'h5678);
      chk("bp_valid_last", {30'd0, out_valid, out_last}, 32'd2);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    drain();
    chk("bp_cnt", {30'd0, expanded_cnt}, 32'd3);

    // Reset while SEND_HI is waiting. The high beat must never appear.
    out_ready = 1'b0;
    send(bp);
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    chk("hi_data", {16'd0, out_data}, 32'h1234);
    chk("hi_last", {31'd0, out_last}, 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    sb.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_mid_cnt", {30'd0, expanded_cnt}, 32'd0);
    @(posedge clk); #1 out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("rst_mid_no_beat", {31'd0, out_valid}, 32'd0);
    end

    // Counter saturation at 2^CNT_W-1.
    foreach (v_sat[i]) begin
      send(v_sat[i]);
      drain();
      chk("sat_cnt", {30'd0, expanded_cnt}, v_sat[i].cnt);
    end
    repeat (3) @(negedge clk);
    chk("sat_cnt_hold", {30'd0, expanded_cnt}, 32'd3);
    chk("sb_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/narrow_32_to_16_tx.md
NARROW_32_TO_16_TX -- requirements
Module: narrow_32_to_16_tx

Interface
REQ-001 Parameter CNT_W, default 16: width of the expanded-word statistics counter.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  upstream holds a 32-bit word.
REQ-005 in_ready  output  1  block can accept a word this cycle.
REQ-006 in_data  input  32  signed word to narrow.
REQ-007 out_valid  output  1  a 16-bit beat is presented.
REQ-008 out_ready  input  1  downstream accepts the beat this cycle.
REQ-009 out_data  output  16  beat payload.
REQ-010 out_compact  output  1  beat is a full word encoded in 16 bits; the receiver sign-extends it to 32.
REQ-011 out_last  output  1  final beat of the current word.
REQ-012 expanded_cnt  output  CNT_W  number of words that needed two beats.

Function
REQ-013 The block SHALL be the transmit end of the 16-to-32 sign-extension path: the receiver rebuilds each 32-bit word from one compact beat or from two beats.
REQ-014 A word SHALL be compact exactly when in_data[31:15] are all equal, i.e. the value lies in -32768..32767.
REQ-015 An input transfer SHALL occur when in_valid and in_ready are both 1; an output transfer when out_valid and out_ready are both 1.
REQ-016 The FSM SHALL have states IDLE, SEND_ONE, SEND_LO and SEND_HI.
REQ-017 In IDLE: in_ready=1 and out_valid=0.
REQ-018 On an input transfer in IDLE, a compact word SHALL go to SEND_ONE and a non-compact word to SEND_LO; the word is captured in a 32-bit holding register.
REQ-019 First-beat latency: out_valid SHALL rise exactly one cycle after the input transfer.
REQ-020 SEND_ONE beat: out_data=word[15:0], out_compact=1, out_last=1; on output transfer go to IDLE.
REQ-021 SEND_LO beat: out_data=word[15:0], out_compact=0, out_last=0; on output transfer go to SEND_HI.
REQ-022 SEND_HI beat: out_data=word[31:16], out_compact=0, out_last=1; on output transfer go to IDLE.
REQ-023 in_ready SHALL be 0 in SEND_ONE, SEND_LO and SEND_HI. Back-to-back throughput is therefore one compact word per 2 cycles and one expanded word per 3 cycles.
REQ-024 While out_valid=1 and out_ready=0, out_data, out_compact and out_last SHALL hold stable, and the state SHALL not change.
REQ-025 out_ready asserted in IDLE SHALL have no effect.
REQ-026 in_data and in_valid SHALL be ignored outside IDLE; no word is dropped and none is duplicated.
REQ-027 expanded_cnt SHALL increment by 1 on each input transfer of a non-compact word.
REQ-028 expanded_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-029 out_data, out_compact and out_last SHALL be driven from registers, with no combinational path from in_data.

Reset
REQ-030 With rst=1 at a clock edge: state=IDLE, the holding register is 0, out_valid=0, out_data=0, out_compact=0, out_last=0, expanded_cnt=0.
REQ-031 Reset SHALL take priority over every transfer in the same cycle.
REQ-032 A word in flight when reset asserts SHALL be discarded; no partial beat is emitted after reset.
REQ-033 in_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-034 The state encoding, the 16/32 width constants and the compact-test function SHALL sit in a shared package, so the receiver uses the same definitions.
REQ-035 The compact test SHALL be a natural sub-module, fits_in_16, with input in[31:0] and output fits; it is purely combinational.
REQ-036 The FSM, the holding register and the counter SHALL remain in narrow_32_to_16_tx.

Verification
REQ-037 Compact word: in_data=0x00007FFF with out_ready=1 -> one beat, 0x7FFF, compact=1, last=1, one cycle after the input transfer; expanded_cnt stays 0.
REQ-038 Negative compact word: in_data=0xFFFF8000 -> one beat, 0x8000, compact=1, last=1.
REQ-039 Boundary values:
- in_data=0x00008000 -> beats 0x8000 (compact=0, last=0) then 0x0000 (last=1); expanded_cnt=1.
- in_data=0xFFFF7FFF -> beats 0x7FFF then 0xFFFF.
REQ-040 Backpressure: hold out_ready=0 for 5 cycles during SEND_LO of word 0x12345678 -> 0x5678 held stable and in_ready=0 throughout; then 0x5678 and 0x1234 are delivered once each.
REQ-041 Reset mid-word: assert rst while in SEND_HI -> next cycle out_valid=0, in_ready=1, expanded_cnt=0, and 0x1234 is never emitted.
REQ-042 Counter saturation: with CNT_W=2, send 5 expanded words -> expanded_cnt reads 3 and stays at 3.
